ks_pipe_sub: RTL and testbench

KS_PIPE_SUB -- requirements
Module: ks_pipe_sub

---
 rtl/ks_pkg.sv | 20 ++
 rtl/ks_prefix_stage.sv | 47 ++++
 rtl/ks_pipe_sub.sv | 111 +++++++++++
 tb/tb_ks_pipe_sub.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and helpers for the Kogge-Stone pipelined subtractor.
// Lane bundle carries propagate/generate/original-propagate per bit.
package ks_pkg;

  typedef struct packed {
    logic p;
    logic g;
    logic po;
  } ks_lane_t;

  typedef struct packed {
    logic valid;
    logic cin;
  } ks_ctl_t;

  function automatic int ks_width(input int widx);
    return 1 << widx;
  endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// One registered Kogge-Stone prefix level of span 2**(LVL-1).
// Bits below the span pass through untouched.
import ks_pkg::*;

module ks_prefix_stage #(
  parameter int LVL = 1,
  parameter int WIDIDX = 3,
  localparam int W = ks_width(WIDIDX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  input  ks_ctl_t             src_ctl,
  input  ks_lane_t [W-1:0]    src_lane,
  output ks_ctl_t             ctl,
  output ks_lane_t [W-1:0]    lane
);

  localparam int SPAN = 1 << (LVL - 1);

  ks_lane_t [W-1:0] nxt;

  for (genvar j = 0; j < W; j++) begin : g_bit
    if (j >= SPAN) begin : g_op
      assign nxt[j] = '{
        p:  src_lane[j].p & src_lane[j-SPAN].p,
        g:  src_lane[j].g
          | (src_lane[j].p & src_lane[j-SPAN].g),
        po: src_lane[j].po
      };
    end else begin : g_pass
      assign nxt[j] = src_lane[j];
    end
  end

  // level register, frozen by the global stall
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl  <= '0;
      lane <= '0;
    end else if (adv) begin
      ctl  <= src_ctl;
      lane <= nxt;
    end
  end

endmodule

// File: rtl/ks_pipe_sub.sv
// Pipelined Kogge-Stone subtractor: Diff = A - B - Bin, WIDIDX+1 stages.
// Optional KS_PIPE_SUB_OVF_EN adds the signed overflow output Ovf.
import ks_pkg::*;

module ks_pipe_sub #(
  parameter int WIDIDX = 3,
  localparam int W = ks_width(WIDIDX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Diff,
`ifdef KS_PIPE_SUB_OVF_EN
  output logic         Bout,
  output logic         Ovf
`else
  output logic         Bout
`endif
);

  logic adv;

  ks_lane_t [W-1:0] lane0_d;
  ks_lane_t [W-1:0] lane0;
  ks_ctl_t          ctl0;

  ks_ctl_t          ctl  [WIDIDX+1];
  ks_lane_t [W-1:0] lane [WIDIDX+1];

  ks_ctl_t          fctl;
  ks_lane_t [W-1:0] flane;
  logic [W:0]       c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // bitwise P/G of A + ~B
  always_comb begin
    lane0_d = '0;
    for (int j = 0; j < W; j++) begin
      lane0_d[j].p  = A[j] ^ ~B[j];
      lane0_d[j].g  = A[j] & ~B[j];
      lane0_d[j].po = A[j] ^ ~B[j];
    end
  end

  // stage 0 register; carry-in is the inverted borrow
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl0  <= '0;
      lane0 <= '0;
    end else if (adv) begin
      ctl0  <= '{valid: in_valid, cin: ~Bin};
      lane0 <= lane0_d;
    end
  end

  assign ctl[0]  = ctl0;
  assign lane[0] = lane0;

  for (genvar i = 1; i <= WIDIDX; i++) begin : g_lvl
    ks_prefix_stage #(
      .LVL    (i),
      .WIDIDX (WIDIDX)
    ) u_lvl (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .src_ctl  (ctl[i-1]),
      .src_lane (lane[i-1]),
      .ctl      (ctl[i]),
      .lane     (lane[i])
    );
  end

  assign fctl  = ctl[WIDIDX];
  assign flane = lane[WIDIDX];

  // group P/G now span bit 0, so the carry-in folds in per bit
  always_comb begin
    c    = '0;
    c[0] = fctl.cin;
    for (int j = 0; j < W; j++) begin
      c[j+1] = flane[j].g | (flane[j].p & fctl.cin);
    end
  end

  // sum bits from original propagate and incoming carries
  always_comb begin
    Diff = '0;
    for (int j = 0; j < W; j++) begin
      Diff[j] = flane[j].po ^ c[j];
    end
  end

  assign out_valid = fctl.valid;

  // zeroed registers read as carry-out 0; mask so idle Bout reads 0
  assign Bout = fctl.valid & ~c[W];

`ifdef KS_PIPE_SUB_OVF_EN
  assign Ovf = c[W-1] ^ c[W];
`endif

endmodule

// File: tb/tb_ks_pipe_sub.sv
// Self-checking bench for ks_pipe_sub (WIDIDX=3).
// Reference model: integer subtraction with an in-order queue.
module tb_ks_pipe_sub;

  localparam int WIDIDX = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef KS_PIPE_SUB_OVF_EN
  logic         Ovf;
`endif

  ks_pipe_sub #(.WIDIDX(WIDIDX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
`ifdef KS_PIPE_SUB_OVF_EN
    .Bout      (Bout),
    .Ovf       (Ovf)
`else
    .Bout      (Bout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nout = 0;
  int   first_out = -1;
  int   last_out = -1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic bi);
    exp_t r;
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sa - sb - int'(bi);
    r.d  = W'(ua - ub - int'(bi));
    r.bo = (ua < ub + int'(bi));
    r.ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    return r;
  endfunction

  // one cycle: drive at negedge, observe, update model on handshakes
  task automatic drive(input logic iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic bi,
                       input logic ordy, input logic r);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    A         = a;
    B         = b;
    Bin       = bi;
    out_ready = ordy;
    rst       = r;
    #1;
    cyc++;
    if (r) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        nout++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("diff", Diff, e.d);
          chk("bout", Bout, e.bo);
`ifdef KS_PIPE_SUB_OVF_EN
          chk("ovf", Ovf, e.ov);
`else
          if (e.ov === 1'bx) chk("ovf_model", 0, 1);
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bi));
    end
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, 1'b0, ordy, 1'b0);
  endtask

  task automatic send_one(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic bi,
                          input logic [W-1:0] ed,
                          input logic eb,
                          input logic eo);
    int lat;
    lat = 0;
    drive(1'b1, a, b, bi, 1'b1, 1'b0);
    chk("acc_rdy", in_ready, 1);
    for (int k = 1; k <= 20; k++) begin
      idle(1'b1);
      if (out_valid) begin
        lat = k;
        chk("dir_diff", Diff, ed);
        chk("dir_bout", Bout, eb);
`ifdef KS_PIPE_SUB_OVF_EN
        chk("dir_ovf", Ovf, eo);
`else
        if (eo === 1'bx) chk("dir_ovf", 0, 1);
`endif
        break;
      end
    end
    chk("latency", lat, WIDIDX + 1);
  endtask

  initial begin
    int npush;

    // reset state
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_irdy", in_ready, 1);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
`ifdef KS_PIPE_SUB_OVF_EN
    chk("rst_ovf", Ovf, 0);
`endif

    // directed vectors with latency
    send_one(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    send_one(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    send_one(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    send_one(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    send_one(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
    send_one(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    send_one(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);

    // back-to-back, no gaps
    nout = 0;
    first_out = -1;
    last_out = -1;
    for (int i = 0; i < 8; i++)
      drive(1'b1, W'($urandom), W'($urandom),
            1'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("b2b_count", nout, 8);
    chk("b2b_span", last_out - first_out, 7);

    // fill while stalled, then hold
    for (int i = 0; i < 6; i++)
      drive(1'b1, W'($urandom), W'($urandom),
            1'($urandom), 1'b0, 1'b0);
    chk("fill_depth", q.size(), WIDIDX + 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'($urandom), W'($urandom),
            1'($urandom), 1'b0, 1'b0);
      chk("stall_irdy", in_ready, 0);
      chk("stall_ovalid", out_valid, 1);
      if (q.size() > 0) chk("stall_diff", Diff, q[0].d);
    end
    nout = 0;
    npush = q.size();
    for (int i = 0; i < 10; i++) begin
      if (in_valid && in_ready) npush++;
      drive(1'b1, W'($urandom), W'($urandom),
            1'($urandom), 1'b1, 1'b0);
    end
    if (in_valid && in_ready) npush++;
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("stall_drain", q.size(), 0);
    chk("stall_count", nout, npush + 10 - 10 - 1 + 1);

    // reset with ops in flight, in_valid high during reset
    for (int i = 0; i < 3; i++)
      drive(1'b1, W'($urandom), W'($urandom),
            1'($urandom), 1'b1, 1'b0);
    drive(1'b1, 8'h55, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("mid_rst_ovalid", out_valid, 0);
    nout = 0;
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("mid_rst_stale", nout, 0);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b1);
    chk("rand_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
